// File: rtl/adda_capture_ctrl.sv
// Trigger-based ADC capture sequencer with circular pre-trigger buffer, valid/ready readout and DAC drive.
// Optional buffer playback to the DAC is compiled in with `define ADDA_PLAYBACK_EN.
module adda_capture_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int PRETRIG = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_ad_sample,
    input  logic       i_arm,
    input  logic       i_abort,
    input  logic       i_force,
    input  logic [7:0] i_threshold,
    input  logic       i_play,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    input  logic       i_rd_ready,
    output logic       o_rd_last,
    output logic [7:0] o_da_value,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_state
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(DEPTH - 1);

    logic [7:0]        ram [DEPTH];
    logic [2:0]        state;
    logic [7:0]        s0, s1;
    logic [ADDR_W-1:0] wptr, tptr, rptr, cnt, rcnt;
    logic              rd_prime;
    logic              trig, writing, xfer;
    logic [ADDR_W-1:0] rd_addr;

    // Readout handshake: a word moves when o_rd_valid & i_rd_ready at a rising edge;
    // o_rd_data/o_rd_valid stay frozen while the consumer holds i_rd_ready low.
    assign trig    = i_force | ((s1 < i_threshold) && (s0 >= i_threshold));
    assign writing = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
    assign xfer    = o_rd_valid & i_rd_ready;
    assign rd_addr = xfer ? rptr + 1'b1 : rptr;

    assign o_busy    = (state != S_IDLE);
    assign o_state   = state;
    assign o_rd_last = o_rd_valid && (rcnt == RD_LAST);

    always_ff @(posedge i_clk) begin
        if (writing) ram[wptr] <= s0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            s0         <= '0;
            s1         <= '0;
            wptr       <= '0;
            tptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            rcnt       <= '0;
            rd_prime   <= 1'b0;
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            s1 <= s0;
            s0 <= i_ad_sample;
            if (writing) wptr <= wptr + 1'b1;
            if (state != S_IDLE && i_abort) begin
                state      <= S_IDLE;
                rd_prime   <= 1'b0;
                o_rd_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_arm && !i_abort) begin
                            state  <= (PRETRIG == 0) ? S_ARMED : S_FILL;
                            wptr   <= '0;
                            cnt    <= '0;
                            o_done <= 1'b0;
                        end
                    end
                    S_FILL: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == FILL_LAST) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (trig) begin
                            tptr <= wptr;
                            cnt  <= ADDR_W'(1);
                            // With a single post-trigger slot the trigger write completes the window.
                            if (PRETRIG == DEPTH - 1) begin
                                state  <= S_READ;
                                rptr   <= wptr - PRE_OFS;
                                rcnt   <= '0;
                                o_done <= 1'b1;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == POST_LAST) begin
                            state  <= S_READ;
                            rptr   <= tptr - PRE_OFS;
                            rcnt   <= '0;
                            o_done <= 1'b1;
                        end
                    end
                    S_READ: begin
                        // One priming cycle lets the registered RAM read settle before valid rises.
                        if (rd_prime) begin
                            o_rd_valid <= 1'b1;
                            rd_prime   <= 1'b0;
                        end else if (!o_rd_valid) begin
                            rd_prime <= 1'b1;
                        end
                        if (xfer) begin
                            rptr <= rptr + 1'b1;
                            rcnt <= rcnt + 1'b1;
                            if (rcnt == RD_LAST) begin
                                state      <= S_IDLE;
                                o_rd_valid <= 1'b0;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_rd_data <= '0;
        else if (state == S_READ) o_rd_data <= ram[rd_addr];
    end

`ifdef ADDA_PLAYBACK_EN
    logic [ADDR_W-1:0] pptr, cap_start;
    logic              play_on;

    assign play_on = (state == S_IDLE) && o_done && i_play && !i_arm;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_da_value <= 8'h80;
            pptr       <= '0;
            cap_start  <= '0;
        end else begin
            if (state == S_READ && rcnt == '0) cap_start <= rptr;
            // Pointer parks on the window start so a new play request begins with word 0.
            if (play_on) begin
                o_da_value <= ram[pptr];
                pptr       <= pptr + 1'b1;
            end else begin
                o_da_value <= s0;
                pptr       <= cap_start;
            end
        end
    end
`else
    logic unused_play;
    assign unused_play = i_play;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_da_value <= 8'h80;
        else o_da_value <= s0;
    end
`endif
endmodule
